// File: rtl/srm_rf_pkg.sv
// Shared index map, storage types and helpers for the SRM register file.
// Index types are sized for the largest supported file; callers zero-extend into ridx_t.
package srm_rf_pkg;

  localparam int RF_MAX_AW = 16;

  localparam int ZERO_IDX = 0;
  localparam int SR_IDX   = 1;
  localparam int PC_IDX   = 2;
  localparam int IR_IDX   = 3;
  localparam int LINK_OFS = 3;

  typedef logic [31:0]          xword_t;
  typedef logic [RF_MAX_AW-1:0] ridx_t;

  // Indices 0..2 are synthesised (zero, status, pc) and never hold state.
  function automatic logic is_special(ridx_t idx);
    return idx <= ridx_t'(PC_IDX);
  endfunction

endpackage

// File: rtl/srm_rf_scoreboard.sv
// Pending-load bits: one per register, set by load issue, cleared by writeback or trap save.
// Latency: lookups are combinational; updates take effect after the clock edge. No backpressure.
module srm_rf_scoreboard
  import srm_rf_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue,
  input  logic [AW-1:0]   issue_sel,
  input  logic            wb,
  input  logic [AW-1:0]   wb_sel,
  input  logic            trap,
  input  logic [NRD*AW-1:0] look,
  output logic [NRD-1:0]  hit
);

  localparam logic [AW-1:0] LINK = AW'(NREGS - LINK_OFS);

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nxt;

  // Clears are applied first so a same-cycle issue to the same index leaves it set.
  always_comb begin
    pend_nxt = pend;
    if (wb)
      pend_nxt[wb_sel] = 1'b0;
    if (trap)
      pend_nxt[LINK] = 1'b0;
    if (issue && !is_special(ridx_t'(issue_sel)))
      pend_nxt[issue_sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pend <= '0;
    else
      pend <= pend_nxt;
  end

  for (genvar g = 0; g < NRD; g++) begin : g_look
    logic [AW-1:0] idx;
    assign idx    = look[g*AW +: AW];
    assign hit[g] = pend[idx] & ~is_special(ridx_t'(idx));
  end

endmodule

// File: rtl/srm_regfile_mp.sv
// Multi-read-port SRM register file with kernel-protected status, trap link save and load scoreboard.
// Reads 0-cycle combinational, writes on clk edge, no backpressure; SRM_RF_BYPASS_EN forwards same-cycle writes.
module srm_regfile_mp
  import srm_rf_pkg::*;
#(
  parameter int              XLEN   = 32,
  parameter int              NREGS  = 32,
  parameter int              NRD    = 2,
  parameter int              SRW    = 4,
  parameter logic [SRW-1:0]  SR_RST = 4'b1000,
  parameter int              KBIT   = 0,
  localparam int             AW     = $clog2(NREGS),
  localparam int             SW     = $clog2(SRW)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     din,
  input  logic                c_we,
  input  logic [AW-1:0]       csel,
  input  logic [NRD*AW-1:0]   rsel,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rpend,
  input  logic [XLEN-1:0]     pc,
  input  logic                ir_tsf,
  input  logic                sr_we,
  input  logic [SW-1:0]       sr_sel,
  input  logic                sr_in,
  input  logic                ks,
  input  logic                ld_issue,
  input  logic [AW-1:0]       ld_sel,
  output logic [XLEN-1:0]     ir,
  output logic [SRW-1:0]      sr
);

  localparam logic [AW-1:0] LINK = AW'(NREGS - LINK_OFS);
  localparam logic [AW-1:0] IR   = AW'(IR_IDX);

  logic [XLEN-1:0] regs [NREGS];
  logic [SRW-1:0]  status;
  logic [SRW-1:0]  status_nxt;
  logic [XLEN-1:0] sr_ext;
  logic [NRD-1:0]  pend_hit;

  // Kernel check uses the pre-edge flag; ks is applied last so it beats a clear of KBIT.
  always_comb begin
    status_nxt = status;
    if (sr_we && status[KBIT] && (int'(sr_sel) < SRW))
      status_nxt[sr_sel] = sr_in;
    if (ks)
      status_nxt[KBIT] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      status <= SR_RST;
    end else begin
      if (c_we && !is_special(ridx_t'(csel)))
        regs[csel] <= din;
      if (ir_tsf)
        regs[LINK] <= pc;
      status <= status_nxt;
    end
  end

  always_comb begin
    sr_ext           = '0;
    sr_ext[SRW-1:0]  = status;
  end

  assign sr = status;

  srm_rf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .issue     (ld_issue),
    .issue_sel (ld_sel),
    .wb        (c_we),
    .wb_sel    (csel),
    .trap      (ir_tsf),
    .look      (rsel),
    .hit       (pend_hit)
  );

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] rd;
    logic            byp;

    assign idx = rsel[g*AW +: AW];

    always_comb begin
      if (idx == AW'(ZERO_IDX))
        base = '0;
      else if (idx == AW'(SR_IDX))
        base = sr_ext;
      else if (idx == AW'(PC_IDX))
        base = pc;
      else
        base = regs[idx];
    end

    // Trap save has priority on LINK, matching the write ordering above.
    always_comb begin
      byp = 1'b0;
      rd  = base;
`ifdef SRM_RF_BYPASS_EN
      if (!rst && !is_special(ridx_t'(idx))) begin
        if (ir_tsf && idx == LINK) begin
          byp = 1'b1;
          rd  = pc;
        end else if (c_we && idx == csel) begin
          byp = 1'b1;
          rd  = din;
        end
      end
`endif
    end

    assign rdata[g*XLEN +: XLEN] = rd;
    assign rpend[g]              = pend_hit[g] & ~byp;
  end

  always_comb begin
    ir = regs[IR];
`ifdef SRM_RF_BYPASS_EN
    if (!rst && c_we && csel == IR)
      ir = din;
`endif
  end

endmodule

// File: tb/tb_srm_regfile_mp.sv
// Directed bench for srm_regfile_mp: expected values queued at drive time, popped at sample time.
module tb_srm_regfile_mp;
  import srm_rf_pkg::*;

`ifdef SRM_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic        c_we;
  logic [4:0]  csel;
  logic [9:0]  rsel;
  logic [63:0] rdata;
  logic [1:0]  rpend;
  logic [31:0] pc;
  logic        ir_tsf;
  logic        sr_we;
  logic [1:0]  sr_sel;
  logic        sr_in;
  logic        ks;
  logic        ld_issue;
  logic [4:0]  ld_sel;
  logic [31:0] ir;
  logic [3:0]  sr;

  int n_cmp = 0;
  int n_err = 0;
  string  tag_q [$];
  xword_t exp_q [$];

  srm_regfile_mp dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .c_we     (c_we),
    .csel     (csel),
    .rsel     (rsel),
    .rdata    (rdata),
    .rpend    (rpend),
    .pc       (pc),
    .ir_tsf   (ir_tsf),
    .sr_we    (sr_we),
    .sr_sel   (sr_sel),
    .sr_in    (sr_in),
    .ks       (ks),
    .ld_issue (ld_issue),
    .ld_sel   (ld_sel),
    .ir       (ir),
    .sr       (sr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string t, input xword_t v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic compare(input xword_t obs);
    string  t;
    xword_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL queue_empty: observed %h required an expected entry", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  task automatic idle();
    c_we = 1'b0; ir_tsf = 1'b0; sr_we = 1'b0; ks = 1'b0; ld_issue = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic sr_step(input logic we, input logic [1:0] sel, input logic val,
                         input logic k, input xword_t expect_sr, input string t);
    sr_we = we; sr_sel = sel; sr_in = val; ks = k;
    push(t, expect_sr);
    step();
    compare(xword_t'(sr));
  endtask

  initial begin
    rst = 1'b1; din = '0; csel = '0; rsel = '0; pc = '0; sr_sel = '0; sr_in = 1'b0; ld_sel = '0;
    idle();
    #12 rst = 1'b0;
    @(posedge clk); #1;

    // 1: populate r5 with a pending load, then reset asynchronously mid-cycle
    c_we = 1'b1; csel = 5'd5; din = 32'hDEAD_BEEF; ld_issue = 1'b1; ld_sel = 5'd5;
    rsel = {5'd0, 5'd5};
    push("t1_r5_written", 32'hDEAD_BEEF);
    push("t1_r5_pending", 32'h1);
    step();
    compare(rdata[31:0]);
    compare(xword_t'(rpend[0]));
    #2 rst = 1'b1;
    #1;
    push("t1_rst_r5", 32'h0);       compare(rdata[31:0]);
    push("t1_rst_sr", 32'h8);       compare(xword_t'(sr));
    push("t1_rst_rpend", 32'h0);    compare(xword_t'(rpend));
    push("t1_rst_ir", 32'h0);       compare(ir);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 2: writes to special indices are dropped
    pc = 32'h0000_1000;
    for (int k = 0; k < 3; k++) begin
      c_we = 1'b1; csel = 5'(k); din = 32'h1234;
      rsel = {5'd7, 5'(k)};
      push("t2_special_read", (k == 0) ? 32'h0 : (k == 1) ? 32'h8 : 32'h1000);
      step();
      compare(rdata[31:0]);
    end
    c_we = 1'b1; csel = 5'd7; din = 32'h1234;
    push("t2_r7_port1", 32'h1234);
    step();
    compare(rdata[63:32]);

    // 3: status protection (KBIT = bit 0, clear after reset)
    sr_step(1'b1, 2'd3, 1'b0, 1'b0, 32'h8, "t3_user_write_blocked");
    sr_step(1'b0, 2'd0, 1'b0, 1'b1, 32'h9, "t3_ks_sets_kernel");
    sr_step(1'b1, 2'd3, 1'b0, 1'b0, 32'h1, "t3_kernel_clear_bit3");
    sr_step(1'b1, 2'd0, 1'b0, 1'b0, 32'h0, "t3_kernel_clears_kbit");
    sr_step(1'b1, 2'd3, 1'b1, 1'b0, 32'h0, "t3_user_set_blocked");
    sr_step(1'b1, 2'd0, 1'b0, 1'b1, 32'h1, "t3_ks_beats_clear");
    sr_step(1'b1, 2'd2, 1'b1, 1'b0, 32'h5, "t3_kernel_set_bit2");
    rsel = {5'd7, 5'd1};
    #1;
    push("t3_sr_via_port", 32'h5);
    compare(rdata[31:0]);

    // 4: trap save beats writeback on LINK and clears its pending bit
    ld_issue = 1'b1; ld_sel = 5'd29; rsel = {5'd7, 5'd29};
    push("t4_link_pending", 32'h1);
    step();
    compare(xword_t'(rpend[0]));
    pc = 32'h400; ir_tsf = 1'b1; c_we = 1'b1; csel = 5'd29; din = 32'h55;
    #1;
    push("t4_link_pre_edge", BYP ? 32'h400 : 32'h0);
    push("t4_rpend_pre_edge", BYP ? 32'h0 : 32'h1);
    compare(rdata[31:0]);
    compare(xword_t'(rpend[0]));
    push("t4_link_saved", 32'h400);
    push("t4_rpend_cleared", 32'h0);
    step();
    compare(rdata[31:0]);
    compare(xword_t'(rpend[0]));

    // 5: scoreboard set/clear priority
    rsel = {5'd9, 5'd8};
    ld_issue = 1'b1; ld_sel = 5'd9;
    push("t5_r9_pending", 32'h1);
    push("t5_r8_clear", 32'h0);
    step();
    compare(xword_t'(rpend[1]));
    compare(xword_t'(rpend[0]));
    c_we = 1'b1; csel = 5'd9; din = 32'h77; ld_issue = 1'b1; ld_sel = 5'd9;
    #1;
    push("t5_rpend_pre_edge", BYP ? 32'h0 : 32'h1);
    compare(xword_t'(rpend[1]));
    push("t5_set_wins", 32'h1);
    step();
    compare(xword_t'(rpend[1]));
    ld_issue = 1'b1; ld_sel = 5'd9;
    push("t5_reissue", 32'h1);
    step();
    compare(xword_t'(rpend[1]));
    c_we = 1'b1; csel = 5'd9; din = 32'h78;
    push("t5_cleared", 32'h0);
    push("t5_r9_data", 32'h78);
    step();
    compare(xword_t'(rpend[1]));
    compare(rdata[63:32]);
    ld_issue = 1'b1; ld_sel = 5'd2; rsel = {5'd2, 5'd8};
    push("t5_special_never_pending", 32'h0);
    step();
    compare(xword_t'(rpend[1]));

    // 6: same-cycle write visibility on a GPR and on IR
    rsel = {5'd3, 5'd4};
    c_we = 1'b1; csel = 5'd4; din = 32'hA5;
    #1;
    push("t6_r4_same_cycle", BYP ? 32'hA5 : 32'h0);
    compare(rdata[31:0]);
    push("t6_r4_next_cycle", 32'hA5);
    step();
    compare(rdata[31:0]);
    c_we = 1'b1; csel = 5'd3; din = 32'hCAFE;
    #1;
    push("t6_ir_same_cycle", BYP ? 32'hCAFE : 32'h0);
    compare(ir);
    push("t6_ir_next_cycle", 32'hCAFE);
    push("t6_ir_via_port", 32'hCAFE);
    step();
    compare(ir);
    compare(rdata[63:32]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
